// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side bundle between the IF/ID, ID/EX registers and the hazard detection unit.
// The master modport drives the pipeline state. The slave modport returns stall, flush and status.
interface hazard_detection_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  ID_EX_MemRead;
  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs1;
  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs2;
  logic                  BranchTaken;
  logic                  count_clr;

  logic                  Stall;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  Flush;
  logic                  stall_q;
  logic                  flush_q;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
           BranchTaken, count_clr,
    input  Stall, PCWrite, IF_ID_Write, Flush, stall_q, flush_q, stall_count, flush_count
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRd, IF_ID_RegisterRs1, IF_ID_RegisterRs2,
           BranchTaken, count_clr,
    output Stall, PCWrite, IF_ID_Write, Flush, stall_q, flush_q, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush generation for the 5-stage core.
// The unit also keeps registered status and saturating event counters.
module hazard_detection_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_detection_unit_if.slave  hif
);

  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic                  load_use;
  logic                  stall;
  logic                  flush;

  logic                  stall_q_q, stall_q_d;
  logic                  flush_q_q, flush_q_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  assign rd  = hif.ID_EX_RegisterRd;
  assign rs1 = hif.IF_ID_RegisterRs1;
  assign rs2 = hif.IF_ID_RegisterRs2;

  // A taken branch squashes the stalled instruction, so flush wins over stall.
  always_comb begin
    load_use = hif.ID_EX_MemRead && (rd != '0) && ((rd == rs1) || (rd == rs2));
    flush    = hif.BranchTaken;
    stall    = load_use && !flush;
  end

  assign hif.Stall       = stall;
  assign hif.Flush       = flush;
  assign hif.PCWrite     = !stall;
  assign hif.IF_ID_Write = !stall;

  always_comb begin
    stall_q_d   = stall;
    flush_q_d   = flush;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hif.count_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q_q   <= 1'b0;
      flush_q_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_q_q   <= stall_q_d;
      flush_q_q   <= flush_q_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_q     = stall_q_q;
  assign hif.flush_q     = flush_q_q;
  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit. It uses 4-bit counters so that saturation is reachable.
// A behavioural model is compared against the DUT on every falling edge, with directed literal checks first.
module tb_hazard_detection_unit;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_detection_unit_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hif ();
  hazard_detection_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_stall_q = 0, m_flush_q = 0, m_sc = 0, m_fc = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model rule: a load whose non-zero destination is read in ID stalls, unless a branch is taken.
  function automatic int exp_stall();
    int rd;
    rd = int'(hif.ID_EX_RegisterRd);
    if (hif.BranchTaken) return 0;
    if (!hif.ID_EX_MemRead || rd == 0) return 0;
    return (rd == int'(hif.IF_ID_RegisterRs1) || rd == int'(hif.IF_ID_RegisterRs2)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stall_q = 0; m_flush_q = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_stall_q = exp_stall();
      m_flush_q = int'(hif.BranchTaken);
      if (hif.count_clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        m_sc = (m_sc + m_stall_q > CMAX) ? CMAX : m_sc + m_stall_q;
        m_fc = (m_fc + m_flush_q > CMAX) ? CMAX : m_fc + m_flush_q;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_Stall",       hif.Stall,       exp_stall());
      chk("m_PCWrite",     hif.PCWrite,     1 - exp_stall());
      chk("m_IF_ID_Write", hif.IF_ID_Write, 1 - exp_stall());
      chk("m_Flush",       hif.Flush,       hif.BranchTaken);
      chk("m_stall_q",     hif.stall_q,     m_stall_q);
      chk("m_flush_q",     hif.flush_q,     m_flush_q);
      chk("m_stall_count", hif.stall_count, m_sc);
      chk("m_flush_count", hif.flush_count, m_fc);
    end
  end

  task automatic apply(input bit mr, input int rd, input int rs1, input int rs2,
                       input bit bt, input bit clr);
    hif.ID_EX_MemRead     = mr;
    hif.ID_EX_RegisterRd  = RW'(rd);
    hif.IF_ID_RegisterRs1 = RW'(rs1);
    hif.IF_ID_RegisterRs2 = RW'(rs2);
    hif.BranchTaken       = bt;
    hif.count_clr         = clr;
    #1;
  endtask

  task automatic comb(string tag, int s, int pcw, int ifw, int f);
    chk({tag, "_Stall"},       hif.Stall,       s);
    chk({tag, "_PCWrite"},     hif.PCWrite,     pcw);
    chk({tag, "_IF_ID_Write"}, hif.IF_ID_Write, ifw);
    chk({tag, "_Flush"},       hif.Flush,       f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply(0, 0, 0, 0, 0, 0);
    #2;
    comb("rst", 0, 1, 1, 0);
    chk("rst_stall_q", hif.stall_q, 0);
    chk("rst_flush_q", hif.flush_q, 0);
    chk("rst_stall_count", hif.stall_count, 0);
    chk("rst_flush_count", hif.flush_count, 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    apply(1, 2, 2, 0, 0, 0); comb("lu_rs1", 1, 0, 0, 0);
    tick();
    chk("lu_rs1_stall_q", hif.stall_q, 1);
    chk("lu_rs1_count", hif.stall_count, 1);
    apply(1, 2, 0, 2, 0, 0); comb("lu_rs2", 1, 0, 0, 0);
    tick();
    chk("lu_rs2_count", hif.stall_count, 2);

    apply(1, 4, 2, 3, 0, 0); comb("nomatch", 0, 1, 1, 0);
    apply(1, 0, 0, 0, 0, 0); comb("x0", 0, 1, 1, 0);
    tick();
    chk("x0_stall_q", hif.stall_q, 0);
    chk("x0_count", hif.stall_count, 2);

    apply(0, 0, 0, 0, 1, 0); comb("br", 0, 1, 1, 1);
    tick();
    chk("br_flush_q", hif.flush_q, 1);
    chk("br_count1", hif.flush_count, 1);
    tick();
    chk("br_count2", hif.flush_count, 2);
    apply(0, 0, 0, 0, 0, 0); comb("nobr", 0, 1, 1, 0);
    tick();
    chk("nobr_flush_q", hif.flush_q, 0);

    apply(1, 5, 5, 0, 1, 0); comb("prio", 0, 1, 1, 1);
    tick();
    chk("prio_flush_count", hif.flush_count, 3);
    chk("prio_stall_count", hif.stall_count, 2);

    apply(1, 7, 7, 7, 0, 0); comb("both", 1, 0, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_stall_count", hif.stall_count, CMAX);
    apply(1, 7, 7, 7, 0, 1);
    tick();
    chk("clr_stall_count", hif.stall_count, 0);
    chk("clr_flush_count", hif.flush_count, 0);
    chk("clr_stall_q", hif.stall_q, 1);

    for (int i = 0; i < 2000; i++) begin
      apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 63) == 0));
      tick();
    end

    apply(1, 3, 3, 0, 0, 0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall_q", hif.stall_q, 0);
    chk("arst_flush_q", hif.flush_q, 0);
    chk("arst_stall_count", hif.stall_count, 0);
    chk("arst_flush_count", hif.flush_count, 0);
    comb("arst", 1, 0, 0, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
